instr_cache: RTL and testbench

//   Direct-mapped, read-only instruction cache feeding the IF stage. Returns one 32-bit

---
 rtl/instr_cache.sv | 179 +++++++++++++++++
 tb/tb_instr_cache.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache.sv
// ---------------------------------------------------------------------------
// instr_cache -- direct-mapped, read-only instruction cache for the IF stage.
//
// A hit returns one 32-bit bundle per cycle ([31:16] mem slot, [15:0] alu
// slot). A miss holds hit low while the whole line is refilled, one word at a
// time, from backing memory. The IF stage stalls the PC while hit==0.
//
// Optional feature: define ICACHE_STATS_EN to add the saturating hit_count and
// miss_count outputs. When it is not defined those ports do not exist.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   pc           in   fetch address (pc[1:0] ignored)
//   invalidate   in   one-cycle pulse that clears every valid bit
//   hit          out  instr2Word is valid for the current pc
//   instr2Word   out  fetched bundle (0 when hit==0)
//   mem_req      out  backing-memory read request
//   mem_addr     out  word-aligned refill address
//   mem_rdata    in   refill data, sampled when mem_req & mem_ack
//   mem_ack      in   acknowledge; consumes the request and returns data
//   dbgState     out  current FSM state (IDLE=0, REFILL=1, FILL_DONE=2)
//   hit_count    out  (ICACHE_STATS_EN) IDLE cycles with hit==1
//   miss_count   out  (ICACHE_STATS_EN) IDLE->REFILL transitions
//
// Handshake: a word transfers on every rising edge where mem_req and mem_ack
// are both 1. mem_req/mem_addr only change on such an edge (or by reset), so
// exactly one request is outstanding; mem_ack while mem_req==0 is ignored.
// ---------------------------------------------------------------------------
module instr_cache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        invalidate,
    output logic        hit,
    output logic [31:0] instr2Word,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  dbgState
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WB   = $clog2(WORDS_PER_LINE);
    localparam int IB   = $clog2(LINES);
    localparam int OFF  = 2 + WB;
    localparam int TAGW = 32 - OFF - IB;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        FILL_DONE = 2'd2
    } stateT;

    stateT             state;
    logic [LINES-1:0]  valid;
    logic [TAGW-1:0]   lineTag;
    logic [IB-1:0]     lineIdx;
    logic [WB-1:0]     wordCnt;
    logic              poisoned;

    // Storage arrays are deliberately left without reset; valid gates them.
    logic [TAGW-1:0]   tagMem  [LINES];
    logic [31:0]       dataMem [LINES][WORDS_PER_LINE];

    logic [TAGW-1:0]   pcTag;
    logic [IB-1:0]     pcIdx;
    logic [WB-1:0]     pcWord;
    logic [1:0]        unusedPcBits;
    logic              lookupHit;
    logic              ackFire;
    logic              lastWord;

    assign pcTag        = pc[31:OFF+IB];
    assign pcIdx        = pc[OFF+IB-1:OFF];
    assign pcWord       = pc[OFF-1:2];
    assign unusedPcBits = pc[1:0];

    // Lookup is only meaningful in IDLE; REFILL and FILL_DONE always report a miss.
    assign lookupHit  = (state == IDLE) && valid[pcIdx] && (tagMem[pcIdx] == pcTag);
    assign hit        = lookupHit;
    assign instr2Word = lookupHit ? dataMem[pcIdx][pcWord] : 32'd0;

    assign ackFire  = mem_req & mem_ack;
    assign lastWord = (wordCnt == WB'(WORDS_PER_LINE - 1));

    // Built from registers only, so it is stable for the whole wait on an ack.
    assign mem_addr = {lineTag, lineIdx, wordCnt, 2'b00};
    assign dbgState = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            valid    <= '0;
            mem_req  <= 1'b0;
            lineTag  <= '0;
            lineIdx  <= '0;
            wordCnt  <= '0;
            poisoned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!lookupHit) begin
                        lineTag  <= pcTag;
                        lineIdx  <= pcIdx;
                        wordCnt  <= '0;
                        poisoned <= 1'b0;
                        mem_req  <= 1'b1;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    // An invalidate seen while the line is in flight means the
                    // data may be stale: finish the burst but never mark it valid.
                    if (invalidate) begin
                        poisoned <= 1'b1;
                    end
                    if (ackFire) begin
                        wordCnt <= wordCnt + WB'(1);
                        if (lastWord) begin
                            mem_req <= 1'b0;
                            state   <= FILL_DONE;
                            if (!poisoned && !invalidate) begin
                                valid[lineIdx] <= 1'b1;
                            end
                        end
                    end
                end
                FILL_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Placed last so it overrides any valid bit set in the same cycle.
            if (invalidate) begin
                valid <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ackFire) begin
            dataMem[lineIdx][wordCnt] <= mem_rdata;
            if (lastWord) begin
                tagMem[lineIdx] <= lineTag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (invalidate) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (lookupHit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state == IDLE) && !lookupHit && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// ---------------------------------------------------------------------------
// tb_instr_cache -- directed scenarios followed by randomized fetches for
// instr_cache (16 lines x 4 words). The reference model is a table of
// {valid, tag} per line plus a backing memory whose word at address A is
// A ^ 32'hA5A5_0000. A negedge responder acks requests after memWait cycles
// and matches every accepted address against the exp_q scoreboard.
// ---------------------------------------------------------------------------
module tb_instr_cache;

    localparam int LINES = 16;
    localparam int WPL   = 4;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        invalidate;
    logic        hit;
    logic [31:0] instr2Word;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  dbgState;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    instr_cache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .invalidate (invalidate),
        .hit        (hit),
        .instr2Word (instr2Word),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .dbgState   (dbgState)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    int          memWait;
    logic        spuriousAck;

    logic        modelValid [LINES];
    logic [23:0] modelTag   [LINES];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hA5A5_0000;
    endfunction

    function automatic logic modelHit(input logic [31:0] a);
        return modelValid[a[7:4]] && (modelTag[a[7:4]] == a[31:8]);
    endfunction

    task automatic modelClear();
        for (int i = 0; i < LINES; i++) modelValid[i] = 1'b0;
    endtask

    task automatic modelFill(input logic [31:0] a);
        modelValid[a[7:4]] = 1'b1;
        modelTag[a[7:4]]   = a[31:8];
    endtask

    task automatic pushLine(input logic [31:0] a);
        for (int w = 0; w < WPL; w++) exp_q.push_back({a[31:4], 4'b0000} + 32'(w * 4));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ---------------- memory responder ----------------
    int          reqWaitCnt;
    logic        prevWaiting;
    logic [31:0] prevAddr;

    initial begin
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        reqWaitCnt  = 0;
        prevWaiting = 1'b0;
        prevAddr    = 32'd0;
    end

    always @(negedge clk) begin
        if (mem_req) begin
            if (prevWaiting) check("req_addr_stable", mem_addr, prevAddr);
            if (reqWaitCnt >= memWait) begin
                mem_ack    = 1'b1;
                mem_rdata  = memWord(mem_addr);
                reqWaitCnt = 0;
                if (exp_q.size() == 0) begin
                    check("req_unexpected", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    check("req_addr", mem_addr, exp_q.pop_front());
                end
            end else begin
                mem_ack    = 1'b0;
                mem_rdata  = $urandom;
                reqWaitCnt = reqWaitCnt + 1;
            end
            prevWaiting = !mem_ack;
            prevAddr    = mem_addr;
        end else begin
            if (prevWaiting && reset) check("req_dropped_early", {31'd0, mem_req}, 32'd1);
            prevWaiting = 1'b0;
            reqWaitCnt  = 0;
            mem_ack     = spuriousAck;
            mem_rdata   = $urandom;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setPc(input logic [31:0] a);
        pc = a;
        #1;
    endtask

    // Starts in a fresh IDLE cycle; returns in the first hit cycle.
    task automatic doMiss(input logic [31:0] a, input int w, input string tag);
        int lat;
        memWait = w;
        pushLine(a);
        setPc(a);
        check({tag, "_miss"}, {31'd0, hit}, 32'd0);
        check({tag, "_miss_data0"}, instr2Word, 32'd0);
        tick();
        lat = 1;
        check({tag, "_req_up"}, {31'd0, mem_req}, 32'd1);
        while (hit !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(2 + WPL * (w + 1)));
        check({tag, "_hit"}, {31'd0, hit}, 32'd1);
        check({tag, "_data"}, instr2Word, memWord(a));
        check({tag, "_req_down"}, {31'd0, mem_req}, 32'd0);
        modelFill(a);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int lat;
        checks      = 0;
        errors      = 0;
        memWait     = 0;
        spuriousAck = 1'b0;
        pc          = 32'd0;
        invalidate  = 1'b0;
        reset       = 1'b0;
        modelClear();

        // Reset state.
        tick();
        tick();
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_data", instr2Word, 32'd0);
        reset = 1'b1;

        // 1: cold miss at 0x40, zero-wait memory.
        doMiss(32'h40, 0, "cold");

        // 2: hit streaming; stray acks while idle must be ignored.
        spuriousAck = 1'b1;
        for (int i = 1; i < WPL; i++) begin
            tick();
            setPc(32'h40 + 32'(i * 4));
            check("stream_hit", {31'd0, hit}, 32'd1);
            check("stream_data", instr2Word, memWord(pc));
            check("stream_noreq", {31'd0, mem_req}, 32'd0);
        end
        tick();
        spuriousAck = 1'b0;
        check("stream_still_hit", {31'd0, hit}, 32'd1);
        check("stream_noreq_after", {31'd0, mem_req}, 32'd0);
`ifdef ICACHE_STATS_EN
        check("stats_hits", hit_count, 32'd4);
        check("stats_misses", miss_count, 32'd1);
`endif

        // 3: conflict on index 4 evicts 0x40.
        tick();
        doMiss(32'h140, 0, "conflict");
        modelValid[4] = 1'b1;
        tick();
        doMiss(32'h40, 0, "evicted");

        // 4: slow memory, 3 wait cycles per word.
        tick();
        doMiss(32'h208, 3, "slow");

        // 5: invalidate during the 2nd refill word of 0x80.
        tick();
        memWait = 0;
        pushLine(32'h80);
        pushLine(32'h80);
        setPc(32'h80);
        check("poison_miss", {31'd0, hit}, 32'd0);
        tick();
        tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        modelClear();
        lat = 3;
        while (hit !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check("poison_latency", 32'(lat), 32'd12);
        check("poison_data", instr2Word, memWord(32'h80));
        modelFill(32'h80);

        // 6: reset in the middle of a refill.
        tick();
        pushLine(32'h40);
        setPc(32'h40);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midrst_req", {31'd0, mem_req}, 32'd0);
        check("midrst_hit", {31'd0, hit}, 32'd0);
        exp_q.delete();
        modelClear();
        tick();
        tick();
        reset = 1'b1;
        doMiss(32'h80, 0, "after_rst_80");
        tick();
        doMiss(32'h40, 0, "after_rst_40");

        // Randomized fetch stream against the model.
        for (int n = 0; n < 60; n++) begin
            tick();
            if ($urandom_range(0, 9) == 0) begin
                invalidate = 1'b1;
                tick();
                invalidate = 1'b0;
                modelClear();
            end
            a = 32'($urandom_range(0, 1)) << 31;
            a = a | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
                  | 32'($urandom_range(0, 15));
            if (modelHit(a)) begin
                setPc(a);
                check("rnd_hit", {31'd0, hit}, 32'd1);
                check("rnd_hit_data", instr2Word, memWord(a));
                check("rnd_hit_noreq", {31'd0, mem_req}, 32'd0);
            end else begin
                doMiss(a, int'($urandom_range(0, 2)), "rnd");
            end
        end

        tick();
        tick();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
